// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, memory-stage controller states and the
// link-address granularity also used by the dcache snoop logic.
package cpu_types_pkg;

  localparam int XLEN = 32;

  // Low address bits ignored when comparing link addresses (word granularity)
  localparam int PKG_LINK_LSB = 2;

  typedef logic [XLEN-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } memctrl_state_t;

endpackage

// File: rtl/memory_access_ctrl_link_reg.sv
// LL/SC link register: holds the linked word address and its valid flag,
// resolves set/clear/snoop priority and produces the SC success compare.
module link_reg
  import cpu_types_pkg::*;
#(
  parameter int WORD_W   = 32,
  parameter int LINK_LSB = PKG_LINK_LSB
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              i_set,         // LL completing this cycle
  input  logic              i_clr,         // successful SC completing, or HALT
  input  logic [WORD_W-1:0] i_addr,        // address of the MEM-stage access
  input  logic              i_snoop_inv,
  input  logic [WORD_W-1:0] i_snoop_addr,
  output logic              o_link_valid,
  output logic              o_sc_ok
);

  logic [WORD_W-1:0] r_link_addr;
  logic              r_link_valid;
  logic              w_snoop_hit;

  // A snoop kills the link if it names the held word, or the word an LL is
  // linking in the same cycle; it always wins over the LL setting the link.
  assign w_snoop_hit = i_snoop_inv &
                       ((i_snoop_addr[WORD_W-1:LINK_LSB] == r_link_addr[WORD_W-1:LINK_LSB]) |
                        (i_set & (i_snoop_addr[WORD_W-1:LINK_LSB] == i_addr[WORD_W-1:LINK_LSB])));

  assign o_sc_ok = r_link_valid &
                   (r_link_addr[WORD_W-1:LINK_LSB] == i_addr[WORD_W-1:LINK_LSB]);

  assign o_link_valid = r_link_valid;

  // Update the link address on LL and the valid flag by priority snoop > set > clear
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_link_addr  <= '0;
      r_link_valid <= 1'b0;
    end else begin
      if (i_set) begin
        r_link_addr <= i_addr;
      end
      if (w_snoop_hit) begin
        r_link_valid <= 1'b0;
      end else if (i_set) begin
        r_link_valid <= 1'b1;
      end else if (i_clr) begin
        r_link_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/memory_access_ctrl.sv
// MEM-stage dcache access controller: issues the load/store request for the
// instruction in MEM, stalls the pipeline until dhit, and captures the word
// (or SC result) for the MEM/WB latch. Owns the LL/SC link register.
module memory_access_ctrl
  import cpu_types_pkg::*;
#(
  parameter int WORD_W   = 32,
  parameter int LINK_LSB = PKG_LINK_LSB
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              valid,
  input  logic              memren,
  input  logic              memwen,
  input  logic              ll,
  input  logic              sc,
  input  logic              halt,
  input  logic [WORD_W-1:0] addr,
  input  logic [WORD_W-1:0] store_data,
  input  logic              dhit,
  input  logic [WORD_W-1:0] dload,
  input  logic              snoop_inv,
  input  logic [WORD_W-1:0] snoop_addr,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [WORD_W-1:0] dmemaddr,
  output logic [WORD_W-1:0] dmemstore,
  output logic              mem_stall,
  output logic [WORD_W-1:0] rdata,
  output logic              link_valid
);

  memctrl_state_t    r_state;
  logic [WORD_W-1:0] r_rdata;

  logic w_access;
  logic w_in_req;
  logic w_req_done;
  logic w_sc_ok;
  logic w_link_set;
  logic w_link_clr;

  assign w_access   = valid & (memren | memwen);
  assign w_in_req   = (r_state == REQ);
  assign w_req_done = w_in_req & dhit;

  // LL links on completion; a completed SC (only reachable when it succeeded)
  // or a HALT reaching MEM drops the link.
  assign w_link_set = w_req_done & memren & ll;
  assign w_link_clr = (w_req_done & memwen & sc) |
                      ((r_state == IDLE) & valid & halt);

  link_reg #(
    .WORD_W   (WORD_W),
    .LINK_LSB (LINK_LSB)
  ) u_link_reg (
    .CLK          (CLK),
    .nRST         (nRST),
    .i_set        (w_link_set),
    .i_clr        (w_link_clr),
    .i_addr       (addr),
    .i_snoop_inv  (snoop_inv),
    .i_snoop_addr (snoop_addr),
    .o_link_valid (link_valid),
    .o_sc_ok      (w_sc_ok)
  );

  // Address and write data go straight through; only the strobes are gated
  assign dmemaddr  = addr;
  assign dmemstore = store_data;
  assign dmemREN   = w_in_req & memren;
  assign dmemWEN   = w_in_req & memwen;
  assign mem_stall = (r_state == IDLE) ? w_access : w_in_req;
  assign rdata     = r_rdata;

  // Sequence each access IDLE -> REQ -> DONE and capture the result word
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
      r_rdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_access) begin
            if (memwen && sc && !w_sc_ok) begin
              // A doomed SC never touches the cache; it just reports failure
              r_state <= DONE;
              r_rdata <= '0;
            end else begin
              r_state <= REQ;
            end
          end
        end
        REQ: begin
          if (dhit) begin
            r_state <= DONE;
            if (memren) begin
              r_rdata <= dload;
            end else if (sc) begin
              r_rdata <= {{(WORD_W-1){1'b0}}, 1'b1};
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access_ctrl.sv
// Self-checking bench for memory_access_ctrl: directed scenarios plus a
// randomized run, all checked against a transaction-level model of the
// access cost, result word and LL/SC link state.
module tb_memory_access_ctrl;

  localparam int OP_LW = 0;
  localparam int OP_SW = 1;
  localparam int OP_LL = 2;
  localparam int OP_SC = 3;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        valid, memren, memwen, ll, sc, halt;
  logic [31:0] addr, store_data;
  logic        dhit;
  logic [31:0] dload;
  logic        snoop_inv;
  logic [31:0] snoop_addr;
  logic        dmemREN, dmemWEN;
  logic [31:0] dmemaddr, dmemstore;
  logic        mem_stall;
  logic [31:0] rdata;
  logic        link_valid;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0] m_rdata;
  logic [31:0] m_la;
  bit          m_lv;

  memory_access_ctrl dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .valid      (valid),
    .memren     (memren),
    .memwen     (memwen),
    .ll         (ll),
    .sc         (sc),
    .halt       (halt),
    .addr       (addr),
    .store_data (store_data),
    .dhit       (dhit),
    .dload      (dload),
    .snoop_inv  (snoop_inv),
    .snoop_addr (snoop_addr),
    .dmemREN    (dmemREN),
    .dmemWEN    (dmemWEN),
    .dmemaddr   (dmemaddr),
    .dmemstore  (dmemstore),
    .mem_stall  (mem_stall),
    .rdata      (rdata),
    .link_valid (link_valid)
  );

  always #5 CLK = ~CLK;

  function automatic bit same_word(input logic [31:0] x, input logic [31:0] y);
    return x[31:2] == y[31:2];
  endfunction

  function automatic string op_name(input int op);
    case (op)
      OP_LW:   return "LW";
      OP_SW:   return "SW";
      OP_LL:   return "LL";
      default: return "SC";
    endcase
  endfunction

  task automatic drive_idle_inputs();
    valid = 0; memren = 0; memwen = 0; ll = 0; sc = 0; halt = 0;
    dhit = 0; snoop_inv = 0;
    dload = $urandom; snoop_addr = $urandom;
  endtask

  // One memory instruction held in MEM until the controller releases it.
  // dhit arrives 'delay' cycles after the first REQ cycle; an optional snoop
  // fires in cycle 's' (cycle 0 is the first IDLE cycle), never after dhit.
  task automatic run_access(input string tag, input int op, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] ld,
                            input int delay, input bit snp, input int s_in,
                            input logic [31:0] sa);
    bit          ok, done;
    int          d, s, exp_stall, exp_req, stall, ren, wen, cyc;
    logic [31:0] old_la;
    bit          is_load;
    is_load   = (op == OP_LW) || (op == OP_LL);
    ok        = (op != OP_SC) || (m_lv && same_word(a, m_la));
    d         = ok ? 1 + delay : 0;
    s         = (s_in > d) ? d : s_in;
    exp_stall = ok ? 2 + delay : 1;
    exp_req   = ok ? 1 + delay : 0;
    stall = 0; ren = 0; wen = 0; cyc = 0; done = 0;
    while (!done && cyc < 20) begin
      @(negedge CLK);
      if (cyc == 0) begin
        valid = 1; halt = 0; addr = a; store_data = wd;
        memren = is_load; memwen = !is_load;
        ll = (op == OP_LL); sc = (op == OP_SC);
      end
      dhit       = ok && (cyc == d);
      dload      = dhit ? ld : $urandom;
      snoop_inv  = snp && (cyc == s);
      snoop_addr = snoop_inv ? sa : $urandom;
      #1;
      stall += int'(mem_stall);
      ren   += int'(dmemREN);
      wen   += int'(dmemWEN);
      if (dmemREN || dmemWEN) begin
        n_cmp++;
        if (dmemaddr !== a || dmemstore !== wd) begin
          n_err++;
          $display("FAIL %s passthru: addr=%h data=%h, expected addr=%h data=%h",
                   tag, dmemaddr, dmemstore, a, wd);
        end
      end
      if (!mem_stall) done = 1;
      cyc++;
    end

    // Model: a snoop before the completing edge acts on the old link; at the
    // completing edge the op takes effect and a coincident snoop still wins.
    if (snp && s < d && same_word(sa, m_la)) m_lv = 0;
    old_la = m_la;
    if (ok) begin
      if (op == OP_LL) begin m_la = a; m_lv = 1; end
      if (op == OP_SC) m_lv = 0;
      if (is_load) m_rdata = ld;
      else if (op == OP_SC) m_rdata = 32'd1;
    end else begin
      m_rdata = 32'd0;
    end
    if (snp && s == d && (same_word(sa, old_la) || (ok && op == OP_LL && same_word(sa, a))))
      m_lv = 0;

    n_cmp++;
    if (!done) begin
      n_err++;
      $display("FAIL %s timeout: stall still high after %0d cycles, expected release after %0d",
               tag, cyc, exp_stall);
    end
    n_cmp++;
    if (stall != exp_stall) begin
      n_err++;
      $display("FAIL %s stall_cycles: got %0d, expected %0d", tag, stall, exp_stall);
    end
    n_cmp++;
    if (ren != (is_load ? exp_req : 0) || wen != (is_load ? 0 : exp_req)) begin
      n_err++;
      $display("FAIL %s req_cycles: REN=%0d WEN=%0d, expected REN=%0d WEN=%0d", tag, ren, wen,
               is_load ? exp_req : 0, is_load ? 0 : exp_req);
    end
    n_cmp++;
    if (rdata !== m_rdata) begin
      n_err++;
      $display("FAIL %s rdata: got %h, expected %h", tag, rdata, m_rdata);
    end
    n_cmp++;
    if (link_valid !== m_lv) begin
      n_err++;
      $display("FAIL %s link_valid: got %b, expected %b", tag, link_valid, m_lv);
    end
    $display("%s: %s addr=%h delay=%0d snoop=%0b@%0d stall=%0d rdata=%h link=%b", tag,
             op_name(op), a, delay, snp, s, stall, rdata, link_valid);
  endtask

  // Non-memory cycle in MEM, optionally a HALT and/or a snoop; link checked next cycle
  task automatic run_idle(input string tag, input bit h, input bit snp, input logic [31:0] sa);
    @(negedge CLK);
    drive_idle_inputs();
    valid = h; halt = h; snoop_inv = snp; snoop_addr = sa;
    #1;
    n_cmp++;
    if (mem_stall !== 1'b0 || dmemREN !== 1'b0 || dmemWEN !== 1'b0) begin
      n_err++;
      $display("FAIL %s idle_outputs: stall=%b REN=%b WEN=%b, expected all 0", tag,
               mem_stall, dmemREN, dmemWEN);
    end
    if (h) m_lv = 0;
    if (snp && same_word(sa, m_la)) m_lv = 0;
    @(negedge CLK);
    drive_idle_inputs();
    #1;
    n_cmp++;
    if (link_valid !== m_lv) begin
      n_err++;
      $display("FAIL %s link_valid: got %b, expected %b", tag, link_valid, m_lv);
    end
    $display("%s: halt=%0b snoop=%0b addr=%h link=%b", tag, h, snp, sa, link_valid);
  endtask

  task automatic test_reset();
    drive_idle_inputs();
    addr = 0; store_data = 0;
    nRST = 0;
    repeat (3) @(negedge CLK);
    #1;
    n_cmp++;
    if (mem_stall !== 0 || dmemREN !== 0 || dmemWEN !== 0 || rdata !== 0 || link_valid !== 0) begin
      n_err++;
      $display("FAIL reset_state: stall=%b REN=%b WEN=%b rdata=%h link=%b, expected all 0",
               mem_stall, dmemREN, dmemWEN, rdata, link_valid);
    end
    @(negedge CLK);
    nRST = 1;
    m_rdata = 0; m_la = 0; m_lv = 0;
    $display("reset: rdata=%h link=%b", rdata, link_valid);
  endtask

  task automatic test_load();
    run_access("lw", OP_LW, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, 1, 0, 0, 0);
  endtask

  task automatic test_store();
    run_access("sw", OP_SW, 32'h0000_0080, 32'h0000_1234, 32'hFFFF_0000, 0, 0, 0, 0);
  endtask

  task automatic test_llsc();
    run_access("ll", OP_LL, 32'h100, 32'h0, 32'h0000_5555, 0, 0, 0, 0);
    run_access("sc", OP_SC, 32'h100, 32'h0000_0007, 32'h0, 0, 0, 0, 0);
  endtask

  task automatic test_snoop();
    run_access("ll_s", OP_LL, 32'h100, 32'h0, 32'hA5A5_0001, 2, 0, 0, 0);
    run_idle("snoop_0x102", 0, 1, 32'h102);
    run_access("sc_fail", OP_SC, 32'h100, 32'h0000_0009, 32'h0, 0, 0, 0, 0);
  endtask

  task automatic test_snoop_same_cycle();
    run_access("ll_snoop_dhit", OP_LL, 32'h100, 32'h0, 32'h1111_2222, 0, 1, 1, 32'h100);
  endtask

  task automatic test_halt();
    run_access("ll_h", OP_LL, 32'h200, 32'h0, 32'h3333_4444, 0, 0, 0, 0);
    run_idle("halt", 1, 0, 0);
  endtask

  task automatic test_back_to_back();
    run_access("b2b_0", OP_LW, 32'h44, 32'h0, 32'h0BAD_F00D, 0, 0, 0, 0);
    run_access("b2b_1", OP_LW, 32'h48, 32'h0, 32'hFEED_0042, 0, 0, 0, 0);
  endtask

  task automatic test_reset_mid();
    run_access("ll_pre", OP_LL, 32'h300, 32'h0, 32'h7777_8888, 0, 0, 0, 0);
    @(negedge CLK);
    drive_idle_inputs();
    valid = 1; memren = 1; addr = 32'h60; store_data = 0;
    @(negedge CLK);
    #1;
    n_cmp++;
    if (dmemREN !== 1'b1) begin
      n_err++;
      $display("FAIL mid_req: REN=%b, expected 1", dmemREN);
    end
    @(negedge CLK);
    nRST = 0;
    #1;
    n_cmp++;
    if (dmemREN !== 0 || dmemWEN !== 0 || rdata !== 0 || link_valid !== 0) begin
      n_err++;
      $display("FAIL mid_reset: REN=%b WEN=%b rdata=%h link=%b, expected 0 0 0 0",
               dmemREN, dmemWEN, rdata, link_valid);
    end
    $display("reset_mid: REN=%b rdata=%h link=%b", dmemREN, rdata, link_valid);
    @(negedge CLK);
    drive_idle_inputs();
    nRST = 1;
    m_rdata = 0; m_la = 0; m_lv = 0;
    run_access("lw_after_rst", OP_LW, 32'h64, 32'h0, 32'hCAFE_D00D, 2, 0, 0, 0);
  endtask

  task automatic test_random();
    logic [31:0] pool [4];
    pool[0] = 32'h100; pool[1] = 32'h104; pool[2] = 32'h102; pool[3] = 32'h200;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        run_idle($sformatf("rnd%0d_idle", i), $urandom_range(0, 3) == 0,
                 $urandom_range(0, 1) == 1, pool[$urandom_range(0, 3)]);
      end else begin
        run_access($sformatf("rnd%0d", i), int'($urandom_range(0, 3)),
                   pool[$urandom_range(0, 3)], $urandom, $urandom,
                   int'($urandom_range(0, 3)), $urandom_range(0, 2) == 0,
                   int'($urandom_range(0, 4)), pool[$urandom_range(0, 3)]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_llsc();
    test_snoop();
    test_snoop_same_cycle();
    test_halt();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
